// File: rtl/bus_ram.sv
// Single-port word RAM behind a valid/ready memory bus, with byte strobes,
// programmable response wait states and out-of-range error reporting.
module bus_ram #(
    parameter int unsigned DEPTH_WORDS = 512,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned BYTES = DEPTH_WORDS * 4;
    localparam int unsigned CW    = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          oor_q, oor_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;

    logic [31:0]   offset;
    logic          in_range;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic          mem_we;

    // Offset arithmetic wraps modulo 2^32, so one unsigned compare covers both bounds.
    always_comb begin
        offset   = mem_addr - BASE_ADDR;
        in_range = (offset < 32'(BYTES));
        word_idx = AW'(offset >> 2);
        rd_word  = mem_q[word_idx];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        oor_d   = oor_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    oor_d  = ~in_range;
                    data_d = in_range ? rd_word : 32'h0;
                    mem_we = in_range && (mem_wstrb != 4'b0000) && resetn;
                    cnt_d  = CW'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                        ready_d = 1'b1;
                        err_d   = ~in_range;
                        rdata_d = in_range ? rd_word : 32'h0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // Master withdrawing the request abandons the response, not the write.
                if (!mem_valid) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_ACK;
                        ready_d = 1'b1;
                        err_d   = oor_q;
                        rdata_d = data_q;
                    end
                end
            end

            ST_ACK: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            oor_q   <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            oor_q   <= oor_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // Array contents survive reset; only strobed lanes are written.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) begin
                    mem_q[word_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_bus_ram.sv
// Randomized self-checking bench: four bus_ram instances with different wait
// states, compared against a byte-lane array model of the memory.
module tb_bus_ram;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0001_0000;
    localparam int          NDUT  = 4;
    localparam int          WS_TAB [NDUT] = '{0, 3, 5, 2};

    logic        clk;
    logic        resetn;
    logic        valid [NDUT];
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready [NDUT];
    logic [31:0] rdata [NDUT];
    logic        err   [NDUT];

    logic [31:0] mem_m [NDUT][DEPTH];
    int          n_checks;
    int          n_fail;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bus_ram #(
            .DEPTH_WORDS(DEPTH),
            .BASE_ADDR  (BASE),
            .WAIT_STATES(WS_TAB[g])
        ) u_dut (
            .clk      (clk),
            .resetn   (resetn),
            .mem_valid(valid[g]),
            .mem_addr (addr),
            .mem_wdata(wdata),
            .mem_wstrb(wstrb),
            .mem_ready(ready[g]),
            .mem_rdata(rdata[g]),
            .mem_err  (err[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one request, hold valid until ready, and return what the DUT answered.
    task automatic access(input int k, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd,
                          output logic er, output int lat);
        @(negedge clk);
        addr     = a;
        wdata    = wd;
        wstrb    = st;
        valid[k] = 1'b1;
        lat      = 0;
        rd       = 32'h0;
        er       = 1'b0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!ready[k] && lat < 64);
        if (ready[k]) begin
            rd = rdata[k];
            er = err[k];
        end else begin
            check("ready_timeout", 32'(ready[k]), 32'd1);
        end
        @(negedge clk);
        valid[k] = 1'b0;
        @(posedge clk);
        #1;
        check("ready_one_cycle", 32'(ready[k]), 32'd0);
    endtask

    // Expected response comes from the model state before the write is applied.
    task automatic xact(input int k, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st);
        longint      off;
        bit          in_rng;
        int          idx;
        logic [31:0] exp_rd;
        logic [31:0] rd;
        logic        er;
        int          lat;
        off    = longint'(a) - longint'(BASE);
        in_rng = (off >= 0) && (off < longint'(DEPTH) * 4);
        exp_rd = 32'h0;
        if (in_rng) begin
            idx    = int'(off / 4);
            exp_rd = mem_m[k][idx];
            for (int b = 0; b < 4; b++) begin
                if (st[b]) mem_m[k][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        access(k, a, wd, st, rd, er, lat);
        check("rdata", rd, exp_rd);
        check("err", 32'(er), 32'(!in_rng));
        check("latency", 32'(lat), 32'(WS_TAB[k] + 1));
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] a;
        logic [3:0]  st;
        int          k;

        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        addr     = '0;
        wdata    = '0;
        wstrb    = '0;
        for (int i = 0; i < NDUT; i++) valid[i] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            check("reset_ready", 32'(ready[i]), 32'd0);
            check("reset_err", 32'(err[i]), 32'd0);
            check("reset_rdata", rdata[i], 32'h0);
        end
        @(negedge clk);
        resetn = 1'b1;

        // Give every word a known value so later reads have a defined expectation.
        for (int d = 0; d < NDUT; d++) begin
            for (int w = 0; w < int'(DEPTH); w++) begin
                a = BASE + 32'(w * 4);
                access(d, a, $urandom, 4'b1111, rd, er, lat);
                mem_m[d][w] = wdata;
                check("fill_err", 32'(er), 32'd0);
            end
        end

        // Zero-wait full write, read back, partial non-contiguous write.
        xact(0, BASE + 32'd8, 32'hDEAD_BEEF, 4'b1111);
        access(0, BASE + 32'd8, 32'h0, 4'b0000, rd, er, lat);
        check("full_word_read", rd, 32'hDEAD_BEEF);
        check("full_word_lat", 32'(lat), 32'd1);
        xact(0, BASE + 32'd8, 32'h1122_3344, 4'b1010);
        access(0, BASE + 32'd8, 32'h0, 4'b0000, rd, er, lat);
        check("strobe_1010", rd, 32'h11AD_33EF);

        for (int s = 0; s < 16; s++) begin
            xact(0, BASE + 32'd20, $urandom, 4'(s));
            xact(0, BASE + 32'd20, 32'h0, 4'b0000);
        end

        // Out-of-range accesses at both edges of the window.
        xact(0, BASE + 32'(DEPTH * 4), 32'hFFFF_FFFF, 4'b1111);
        xact(0, BASE, 32'h0, 4'b0000);
        access(0, BASE - 32'd4, 32'h0, 4'b0000, rd, er, lat);
        check("oor_low_rdata", rd, 32'h0);
        check("oor_low_err", 32'(er), 32'd1);
        xact(0, BASE + 32'(DEPTH * 4) - 32'd4, 32'h0, 4'b0000);

        xact(1, BASE + 32'd8, 32'h0, 4'b0000);

        // Request held through ACK: the next acceptance waits for IDLE.
        @(negedge clk);
        addr     = BASE + 32'd8;
        wstrb    = 4'b0000;
        valid[1] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            check("held_valid_ready", 32'(ready[1]),
                  32'((n == WS_TAB[1] + 1) || (n == 2 * WS_TAB[1] + 3)));
        end
        @(negedge clk);
        valid[1] = 1'b0;
        repeat (3) @(posedge clk);

        // Randomized traffic over all instances, including out-of-range hits.
        for (int t = 0; t < 300; t++) begin
            k = int'($urandom_range(0, NDUT - 1));
            case ($urandom_range(0, 9))
                0:       a = BASE - 32'(4 * $urandom_range(1, 4)) + 32'($urandom_range(0, 3));
                1:       a = BASE + 32'(DEPTH * 4) + 32'($urandom_range(0, 15));
                default: a = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            endcase
            st = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            xact(k, a, $urandom, st);
        end

        // Reset during WAIT aborts the response but keeps the committed write.
        @(negedge clk);
        addr     = BASE + 32'd12;
        wdata    = 32'hA5A5_0F0F;
        wstrb    = 4'b1111;
        valid[2] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        resetn   = 1'b0;
        valid[2] = 1'b0;
        #1;
        check("abort_ready", 32'(ready[2]), 32'd0);
        check("abort_err", 32'(err[2]), 32'd0);
        check("abort_rdata", rdata[2], 32'h0);
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            check("abort_no_ready", 32'(ready[2]), 32'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        mem_m[2][3] = 32'hA5A5_0F0F;
        xact(2, BASE + 32'd12, 32'h0, 4'b0000);

        // Valid withdrawn during WAIT: no response, write stands, next request normal.
        @(negedge clk);
        addr     = BASE + 32'd16;
        wdata    = 32'hCAFE_0001;
        wstrb    = 4'b1111;
        valid[3] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid[3] = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk);
            #1;
            check("drop_no_ready", 32'(ready[3]), 32'd0);
        end
        mem_m[3][4] = 32'hCAFE_0001;
        access(3, BASE + 32'd16, 32'h0, 4'b0000, rd, er, lat);
        check("drop_rdata", rd, 32'hCAFE_0001);
        check("drop_latency", 32'(lat), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
